i2c_dri: RTL

I2C_DRI -- requirements
Module: i2c_dri

---
 rtl/i2c_dri_pkg.sv | 35 +++
 rtl/i2c_tick_gen.sv | 37 +++
 rtl/i2c_dri.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/i2c_dri_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_dri_pkg
// Brief    : Shared types and constants for the I2C EEPROM-style master.
// Revision : 1.0
// ============================================================================
package i2c_dri_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        SLADDR_W,
        ADDR_H,
        ADDR_L,
        WR_DATA,
        RSTART,
        SLADDR_R,
        RD_DATA,
        STOP
    } state_t;

    // Quarter-bit phases of one SCL period
    localparam logic [1:0] c_ph_update = 2'd0;
    localparam logic [1:0] c_ph_rise   = 2'd1;
    localparam logic [1:0] c_ph_sample = 2'd2;
    localparam logic [1:0] c_ph_fall   = 2'd3;

    localparam logic c_rw_write = 1'b0;
    localparam logic c_rw_read  = 1'b1;

    // Bit index of the ninth (acknowledge) bit of every byte
    localparam logic [3:0] c_ack_bit = 4'd8;

endpackage
`default_nettype wire

// File: rtl/i2c_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : i2c_tick_gen
// Brief    : Quarter-bit tick: one-cycle pulse every DIV clocks while enabled.
// Revision : 1.0
// ============================================================================
module i2c_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            tick  <= 1'b0;
        end else if (!en) begin
            r_cnt <= '0;
            tick  <= 1'b0;
        end else if (r_cnt == CW'(DIV - 1)) begin
            r_cnt <= '0;
            tick  <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            tick  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_dri.sv
`default_nettype none
// ============================================================================
// Module   : i2c_dri
// Brief    : Single-byte I2C master (write or random read, 8/16-bit address).
// Revision : 1.0
// ============================================================================
module i2c_dri
    import i2c_dri_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'b1010000,
    parameter int         CLK_FREQ   = 50_000_000,
    parameter int         I2C_FREQ   = 250_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exec,
    input  logic        we,
    input  logic        addr_hl,
    input  logic [15:0] word_addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        i2c_done,
    output logic        i2c_ack,
    output logic        scl,
    inout  wire         sda
);

    localparam int DIV_RAW = CLK_FREQ / (I2C_FREQ * 4);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

    state_t      r_state, w_next_state;
    logic        w_tick;
    logic [1:0]  r_phase;
    logic [3:0]  r_bit_cnt;
    logic        r_we, r_addr_hl;
    logic [15:0] r_word_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rx;
    logic        r_sda_low;
    logic [7:0]  w_tx_byte;
    logic        w_sda_in, w_ack_slot, w_phase_end, w_byte_end;

    assign sda         = r_sda_low ? 1'b0 : 1'bz;
    assign w_sda_in    = sda;
    assign w_ack_slot  = (r_bit_cnt == c_ack_bit);
    assign w_phase_end = w_tick && (r_phase == c_ph_fall);
    assign w_byte_end  = w_phase_end && w_ack_slot;

    i2c_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (r_state != IDLE),
        .tick  (w_tick)
    );

    always_comb begin
        w_tx_byte = 8'h00;
        case (r_state)
            SLADDR_W: w_tx_byte = {SLAVE_ADDR, c_rw_write};
            ADDR_H:   w_tx_byte = r_word_addr[15:8];
            ADDR_L:   w_tx_byte = r_word_addr[7:0];
            WR_DATA:  w_tx_byte = r_wdata;
            SLADDR_R: w_tx_byte = {SLAVE_ADDR, c_rw_read};
            default:  w_tx_byte = 8'h00;
        endcase
    end

    // i2c_ack is already set by the sample phase when the byte ends on a NACK
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (exec) w_next_state = START;
            START:    if (w_phase_end) w_next_state = SLADDR_W;
            SLADDR_W: if (w_byte_end) w_next_state = i2c_ack ? STOP : (r_addr_hl ? ADDR_H : ADDR_L);
            ADDR_H:   if (w_byte_end) w_next_state = i2c_ack ? STOP : ADDR_L;
            ADDR_L:   if (w_byte_end) w_next_state = i2c_ack ? STOP : (r_we ? WR_DATA : RSTART);
            WR_DATA:  if (w_byte_end) w_next_state = STOP;
            RSTART:   if (w_phase_end) w_next_state = SLADDR_R;
            SLADDR_R: if (w_byte_end) w_next_state = i2c_ack ? STOP : RD_DATA;
            RD_DATA:  if (w_byte_end) w_next_state = STOP;
            STOP:     if (w_phase_end) w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= 2'd0;
            r_bit_cnt   <= 4'd0;
            r_we        <= 1'b0;
            r_addr_hl   <= 1'b0;
            r_word_addr <= 16'h0000;
            r_wdata     <= 8'h00;
            r_rx        <= 8'h00;
            r_sda_low   <= 1'b0;
            scl         <= 1'b1;
            rdata       <= 8'h00;
            i2c_done    <= 1'b0;
            i2c_ack     <= 1'b0;
        end else begin
            i2c_done <= 1'b0;
            if (r_state == IDLE) begin
                r_phase   <= 2'd0;
                r_bit_cnt <= 4'd0;
                if (exec) begin
                    r_we        <= we;
                    r_addr_hl   <= addr_hl;
                    r_word_addr <= word_addr;
                    r_wdata     <= wdata;
                    i2c_ack     <= 1'b0;
                end
            end else if (w_tick) begin
                r_phase <= r_phase + 2'd1;
                case (r_state)
                    START, RSTART: begin
                        case (r_phase)
                            c_ph_update: r_sda_low <= 1'b0;
                            c_ph_rise:   scl       <= 1'b1;
                            c_ph_sample: r_sda_low <= 1'b1;
                            default:     scl       <= 1'b0;
                        endcase
                    end
                    STOP: begin
                        case (r_phase)
                            c_ph_update: r_sda_low <= 1'b1;
                            c_ph_rise:   scl       <= 1'b1;
                            c_ph_sample: r_sda_low <= 1'b0;
                            default:     i2c_done  <= 1'b1;
                        endcase
                    end
                    RD_DATA: begin
                        case (r_phase)
                            c_ph_update: r_sda_low <= 1'b0;
                            c_ph_rise:   scl       <= 1'b1;
                            c_ph_sample: if (!w_ack_slot) r_rx <= {r_rx[6:0], w_sda_in};
                            default: begin
                                scl <= 1'b0;
                                if (w_ack_slot) begin
                                    r_bit_cnt <= 4'd0;
                                    rdata     <= r_rx;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 4'd1;
                                end
                            end
                        endcase
                    end
                    SLADDR_W, ADDR_H, ADDR_L, WR_DATA, SLADDR_R: begin
                        case (r_phase)
                            c_ph_update: r_sda_low <= w_ack_slot ? 1'b0 : ~w_tx_byte[~r_bit_cnt[2:0]];
                            c_ph_rise:   scl       <= 1'b1;
                            c_ph_sample: if (w_ack_slot && w_sda_in) i2c_ack <= 1'b1;
                            default: begin
                                scl       <= 1'b0;
                                r_bit_cnt <= w_ack_slot ? 4'd0 : r_bit_cnt + 4'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
